// File: rtl/decoder_pkg.sv
// Shared constants, state encoding and code-range helper for the decoder feeder slice.
package decoder_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CODE_MIN = 8'd33;
    localparam logic [BYTE_W-1:0] CODE_MAX = 8'd48;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } feeder_state_t;

    function automatic logic code_in_range(input logic [BYTE_W-1:0] code);
        return (code >= CODE_MIN) && (code <= CODE_MAX);
    endfunction

endpackage

// File: rtl/decoder_feeder_if.sv
// Byte-stream handshake from the UART receiver into the decoder feeder.
interface decoder_feeder_if;
    import decoder_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/decoder_feeder_fifo.sv
// Byte FIFO for the decoder feeder; power-of-two depth, extra pointer bit separates full from empty.
module feeder_fifo
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_feeder.sv
// Buffers received ASCII bytes and presents them to the decoder with a setup/strobe/hold sequence.
// Optional FEEDER_FILTER_EN: drop bytes outside CODE_MIN..CODE_MAX and count them.
module decoder_feeder
    import decoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    decoder_feeder_if.slave   rx,
    output logic [BYTE_W-1:0] ascii_code,
    output logic              new_data,
    output logic              busy,
    output logic [7:0]        drop_count
);

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

    feeder_state_t     state;
    logic [3:0]        setup_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              accept;
    logic [BYTE_W-1:0] fifo_dout;

    assign rx.rx_ready = !fifo_full;
    assign accept      = rx.rx_valid && !fifo_full;
    assign fifo_pop    = (state == IDLE) && !fifo_empty;
    assign busy        = !fifo_empty || (state != IDLE);

`ifdef FEEDER_FILTER_EN
    // Out-of-range bytes are still acknowledged so the receiver never stalls on them.
    assign fifo_push = accept && code_in_range(rx.rx_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (accept && !code_in_range(rx.rx_data) && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`else
    assign fifo_push  = accept;
    assign drop_count = '0;
`endif

    feeder_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rx.rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ascii_code <= '0;
            new_data   <= 1'b0;
            setup_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        ascii_code <= fifo_dout;
                        setup_cnt  <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt == SETUP_LAST) begin
                        new_data <= 1'b1;
                        state    <= STROBE;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end
                STROBE: begin
                    new_data <= 1'b0;
                    state    <= HOLD;
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_feeder.sv
// Self-checking bench for decoder_feeder: directed tables/sequences plus random traffic vs a queue-based model.
module tb_decoder_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SETUP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ascii_code;
    logic [7:0] drop_count;
    logic       new_data;
    logic       busy;

    decoder_feeder_if rx_if ();

    decoder_feeder #(
        .FIFO_DEPTH   (DEPTH),
        .SETUP_CYCLES (SETUP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_if),
        .ascii_code (ascii_code),
        .new_data   (new_data),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus the time each presented byte strobes and frees the decoder.
    logic [7:0] mq[$];
    int         cyc = 0;
    int         next_free;
    int         pulse_at;
    int         m_drop;
    logic [7:0] m_code;

    int         pulse_cyc[$];
    logic [7:0] pulse_code[$];

    typedef struct {
        bit         v;
        logic [7:0] d;
        logic [7:0] exp_code;
        bit         exp_new;
        bit         exp_busy;
        bit         exp_ready;
    } vec_t;

    vec_t tbl[6];

    function automatic bit passes(input logic [7:0] d);
`ifdef FEEDER_FILTER_EN
        return (d >= 8'd33) && (d <= 8'd48);
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        next_free = 0;
        pulse_at  = -1;
        m_code    = 8'd0;
        m_drop    = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, output bit acc);
        bit ready_b;
        rx_if.rx_valid = v;
        rx_if.rx_data  = d;
        @(posedge clk);
        ready_b = (mq.size() < DEPTH);
        cyc++;
        if (cyc >= next_free && mq.size() > 0) begin
            m_code    = mq.pop_front();
            next_free = cyc + SETUP + 3;
            pulse_at  = cyc + SETUP;
        end
        acc = v && ready_b;
        if (acc) begin
            if (passes(d)) mq.push_back(d);
            else if (m_drop < 255) m_drop++;
        end
        #1;
        chk("ascii_code", ascii_code, m_code);
        chk("new_data", new_data, int'(cyc == pulse_at));
        chk("busy", busy, int'((mq.size() > 0) || (cyc < next_free - 1)));
        chk("rx_ready", rx_if.rx_ready, int'(mq.size() < DEPTH));
        chk("drop_count", drop_count, m_drop);
        if (new_data) begin
            pulse_cyc.push_back(cyc);
            pulse_code.push_back(ascii_code);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        bit         saw_full;
        bit         got_pulse;
        int         n;
        logic [7:0] seq3[3];
        logic [7:0] fl[3];
        logic [7:0] rd;

        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'd0;
        model_reset();

        // Reset values while rst is held
        #2;
        chk("rst_ascii_code", ascii_code, 0);
        chk("rst_new_data", new_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_count", drop_count, 0);
        #10 rst = 1'b0;

        // Single byte 33 into an idle block
        tbl[0] = '{1'b1, 8'd33, 8'd0,  1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 8'd0,  8'd33, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 8'd0,  8'd33, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 8'd0,  8'd33, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 8'd0,  8'd33, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'd0,  8'd33, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].d, acc);
            chk("tbl_ascii_code", ascii_code, tbl[i].exp_code);
            chk("tbl_new_data", new_data, tbl[i].exp_new);
            chk("tbl_busy", busy, tbl[i].exp_busy);
            chk("tbl_rx_ready", rx_if.rx_ready, tbl[i].exp_ready);
        end

        // Back-to-back bytes with rx_valid held
        pulse_cyc.delete();
        pulse_code.delete();
        seq3 = '{8'd33, 8'd34, 8'd45};
        for (int i = 0; i < 3; i++) step(1'b1, seq3[i], acc);
        idle(16);
        chk("b2b_pulses", pulse_code.size(), 3);
        if (pulse_code.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("b2b_code", pulse_code[i], seq3[i]);
            chk("b2b_gap0", pulse_cyc[1] - pulse_cyc[0], 4);
            chk("b2b_gap1", pulse_cyc[2] - pulse_cyc[1], 4);
        end

        // Six bytes offered continuously: FIFO fills, pointers wrap, order kept
        pulse_cyc.delete();
        pulse_code.delete();
        saw_full = 1'b0;
        n = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            step(1'b1, 8'(33 + n), acc);
            if (acc) n++;
            if (!rx_if.rx_ready) saw_full = 1'b1;
        end
        chk("fill_accepted", n, 6);
        chk("fill_full_seen", saw_full, 1);
        idle(30);
        chk("fill_pulses", pulse_code.size(), 6);
        if (pulse_code.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("fill_code", pulse_code[i], 33 + i);
        end

`ifdef FEEDER_FILTER_EN
        // Filter: only 40 forwarded
        pulse_code.delete();
        pulse_cyc.delete();
        fl = '{8'd65, 8'd40, 8'd10};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, fl[i], acc);
            chk("filt_accept", acc, 1);
        end
        idle(10);
        chk("filt_pulses", pulse_code.size(), 1);
        if (pulse_code.size() == 1) chk("filt_code", pulse_code[0], 40);
        chk("filt_drop_count", drop_count, 2);
`endif

        // 300 out-of-range bytes
        n = 0;
        for (int k = 0; k < 3000 && n < 300; k++) begin
            step(1'b1, 8'd10, acc);
            if (acc) n++;
        end
        chk("sat_accepted", n, 300);
`ifdef FEEDER_FILTER_EN
        chk("sat_drop_count", drop_count, 255);
`else
        chk("sat_drop_count", drop_count, 0);
`endif
        idle(30);

        // Reset during STROBE with two bytes queued
        got_pulse = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && !got_pulse; k++) begin
            step(n < 3, 8'(33 + n), acc);
            if (acc) n++;
            if (new_data) got_pulse = 1'b1;
        end
        chk("rst_strobe_reached", got_pulse, 1);
        chk("rst_queued", mq.size(), 2);
        rst = 1'b1;
        model_reset();
        #1;
        chk("abort_new_data", new_data, 0);
        chk("abort_ascii_code", ascii_code, 0);
        chk("abort_busy", busy, 0);
        chk("abort_drop_count", drop_count, 0);
        #2 rst = 1'b0;
        pulse_code.delete();
        pulse_cyc.delete();
        idle(20);
        chk("abort_no_pulse", pulse_code.size(), 0);

        // Random traffic against the model
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) == 0) rd = 8'($urandom_range(0, 255));
            else rd = 8'(33 + $urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), rd, acc);
        end
        idle(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
